data_mem_responder: RTL and testbench

//  Responder (slave) end of the core's data-memory request path: accepts byte-lane read/write

---
 rtl/data_mem_if.sv | 24 ++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store request and response channel between the core's memory-access
// stage (master) and a data-memory responder (slave).
interface data_mem_if;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [3:0]  req_rden;
  logic [3:0]  req_wren;
  logic [31:0] req_wrdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rddata;
  logic        rsp_err;

  modport master (
    output req_vld, req_addr, req_rden, req_wren, req_wrdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rddata, rsp_err
  );

  modport slave (
    input  req_vld, req_addr, req_rden, req_wren, req_wrdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rddata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: byte-lane word RAM served after a
// fixed number of wait states, with a registered valid/ready response.
module data_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          WAIT_CYC   = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input logic      clk,
  input logic      rst,
  data_mem_if.slave bus
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  function automatic logic mask_ok(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    lane_bits = '0;
    for (int i = 0; i < 4; i++) lane_bits[8*i +: 8] = {8{m[i]}};
  endfunction

  logic [31:0]           offset;
  logic [3:0]            mask;
  logic                  req_err;
  logic                  accept;
  logic                  enter_resp;
  logic [DEPTH_LOG2-1:0] idx_p0,    cur_idx;
  logic [3:0]            mask_p0,   cur_mask;
  logic [31:0]           wrdata_p0, cur_wrdata;
  logic                  err_p0,    cur_err;
  logic                  wr_p0,     cur_wr;

  assign bus.req_rdy = (state == IDLE) & ~rst;
  assign accept      = bus.req_vld & bus.req_rdy;

  // Request decode: unsigned offset wraps huge below BASE_ADDR, so one compare covers both bounds
  always_comb begin
    offset  = bus.req_addr - BASE_ADDR;
    mask    = bus.req_rden | bus.req_wren;
    req_err = ({1'b0, offset} >= SPAN)
            | ((|bus.req_rden) == (|bus.req_wren))
            | ~mask_ok(mask);
  end

  // Zero wait states go IDLE->RESP on the accept edge, so the live request is used there
  always_comb begin
    if (state == IDLE) begin
      cur_idx    = offset[DEPTH_LOG2+1:2];
      cur_mask   = mask;
      cur_wrdata = bus.req_wrdata;
      cur_err    = req_err;
      cur_wr     = |bus.req_wren;
    end else begin
      cur_idx    = idx_p0;
      cur_mask   = mask_p0;
      cur_wrdata = wrdata_p0;
      cur_err    = err_p0;
      cur_wr     = wr_p0;
    end
    enter_resp = ((state == IDLE) & accept & (WAIT_CYC == 0))
               | ((state == WAIT) & (cnt == 4'd0));
  end

  // Stage p0: request capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0    <= offset[DEPTH_LOG2+1:2];
      mask_p0   <= mask;
      wrdata_p0 <= bus.req_wrdata;
      err_p0    <= req_err;
      wr_p0     <= |bus.req_wren;
    end
  end

  // RAM commit on RESP entry; a reset on that edge discards the write
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !cur_err && cur_wr) begin
      for (int i = 0; i < 4; i++)
        if (cur_mask[i]) mem[cur_idx][8*i +: 8] <= cur_wrdata[8*i +: 8];
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.rsp_vld    <= 1'b0;
      bus.rsp_rddata <= 32'd0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (WAIT_CYC == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_LD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            state       <= IDLE;
            bus.rsp_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        bus.rsp_vld    <= 1'b1;
        bus.rsp_err    <= cur_err;
        bus.rsp_rddata <= (cur_err | cur_wr) ? 32'd0 : (mem[cur_idx] & lane_bits(cur_mask));
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (2 and 0 wait states)
// checked against a word-array model of the memory and the error rules.
module tb_data_mem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_if bus2 ();
  data_mem_if bus0 ();

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(2), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));
  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  int          sel = 0;
  logic        req_vld = 1'b0;
  logic        rsp_rdy = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wrdata = '0;
  logic [3:0]  req_rden = '0;
  logic [3:0]  req_wren = '0;

  assign bus2.req_vld    = req_vld & (sel == 0);
  assign bus0.req_vld    = req_vld & (sel == 1);
  assign bus2.rsp_rdy    = rsp_rdy & (sel == 0);
  assign bus0.rsp_rdy    = rsp_rdy & (sel == 1);
  assign bus2.req_addr   = req_addr;
  assign bus0.req_addr   = req_addr;
  assign bus2.req_rden   = req_rden;
  assign bus0.req_rden   = req_rden;
  assign bus2.req_wren   = req_wren;
  assign bus0.req_wren   = req_wren;
  assign bus2.req_wrdata = req_wrdata;
  assign bus0.req_wrdata = req_wrdata;

  logic        o_req_rdy, o_rsp_vld, o_rsp_err;
  logic [31:0] o_rsp_rddata;
  always_comb begin
    o_req_rdy    = (sel == 0) ? bus2.req_rdy    : bus0.req_rdy;
    o_rsp_vld    = (sel == 0) ? bus2.rsp_vld    : bus0.rsp_vld;
    o_rsp_err    = (sel == 0) ? bus2.rsp_err    : bus0.rsp_err;
    o_rsp_rddata = (sel == 0) ? bus2.rsp_rddata : bus0.rsp_rddata;
  end

  logic [31:0] mdl [2][NW];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a, input logic [3:0] rd, input logic [3:0] wr);
    longint ua = a;
    longint ub = BASE;
    longint off = ua - ub;
    logic [3:0] m = rd | wr;
    bit range_ok = (off >= 0) && (off < 4 * 1024);
    bit dir_ok   = (rd != 0) != (wr != 0);
    bit shape_ok = m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    return !(range_ok && dir_ok && shape_ok);
  endfunction

  task automatic txn(input logic [31:0] addr, input logic [3:0] rden, input logic [3:0] wren,
                     input logic [31:0] data, input int hold, output logic [31:0] rd);
    bit          e;
    int          idx, k, lat, exp_lat;
    logic [31:0] exp_rd, got_rd;
    logic        got_err;
    e       = exp_err(addr, rden, wren);
    idx     = int'((addr - BASE) >> 2);
    exp_rd  = 32'd0;
    exp_lat = (sel == 0) ? 3 : 1;
    rd      = 32'd0;
    if (!e && idx >= NW) e = 1'b1;  // never generated: model only covers NW words
    if (!e && rden != 0)
      for (int i = 0; i < 4; i++)
        if (rden[i]) exp_rd[8*i +: 8] = mdl[sel][idx][8*i +: 8];

    @(negedge clk);
    req_addr = addr; req_rden = rden; req_wren = wren; req_wrdata = data;
    req_vld = 1'b1;
    rsp_rdy = (hold == 0);
    k = 0;
    while (!o_req_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!o_req_rdy) begin
      check("req_rdy_timeout", 32'd0, 32'd1);
      req_vld = 1'b0; rsp_rdy = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    req_addr = $urandom; req_rden = 4'($urandom); req_wren = 4'($urandom); req_wrdata = $urandom;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_rsp_vld && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    if (!o_rsp_vld) begin
      rsp_rdy = 1'b0;
      return;
    end
    got_err = o_rsp_err;
    got_rd  = o_rsp_rddata;
    rd      = got_rd;
    check("rsp_err", {31'd0, got_err}, {31'd0, e});
    check("rsp_rddata", got_rd, exp_rd);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_vld", {31'd0, o_rsp_vld}, 32'd1);
      check("hold_data", o_rsp_rddata, got_rd);
      check("hold_err", {31'd0, o_rsp_err}, {31'd0, got_err});
      check("hold_req_rdy", {31'd0, o_req_rdy}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 1'b0;
    @(negedge clk);
    check("post_vld", {31'd0, o_rsp_vld}, 32'd0);
    check("post_req_rdy", {31'd0, o_req_rdy}, 32'd1);

    if (!e && wren != 0)
      for (int i = 0; i < 4; i++)
        if (wren[i]) mdl[sel][idx][8*i +: 8] = data[8*i +: 8];
  endtask

  logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic rand_txn();
    logic [31:0] a, d, rd;
    logic [3:0]  m, rden, wren;
    int          r;
    r = $urandom_range(0, 9);
    if (r == 0)
      a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 8))
                                      : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 8));
    else
      a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
    m = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
    r = $urandom_range(0, 9);
    rden = 4'd0; wren = 4'd0;
    if (r == 0)      begin rden = m; wren = m; end
    else if (r == 1) begin rden = 4'd0; wren = 4'd0; end
    else if (r < 6)  rden = m;
    else             wren = m;
    d = $urandom;
    txn(a, rden, wren, d, $urandom_range(0, 5), rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        saw_vld;

    // Reset held three edges
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_rdy2", {31'd0, bus2.req_rdy}, 32'd0);
    check("rst_req_rdy0", {31'd0, bus0.req_rdy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld2", {31'd0, bus2.rsp_vld}, 32'd0);
    check("rst_err2", {31'd0, bus2.rsp_err}, 32'd0);
    check("rst_data2", bus2.rsp_rddata, 32'd0);
    check("rst_vld0", {31'd0, bus0.rsp_vld}, 32'd0);
    check("rst_err0", {31'd0, bus0.rsp_err}, 32'd0);
    check("rst_data0", bus0.rsp_rddata, 32'd0);
    check("rst_req_rdy_hold", {31'd0, bus2.req_rdy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("req_rdy_after_rst2", {31'd0, bus2.req_rdy}, 32'd1);
    check("req_rdy_after_rst0", {31'd0, bus0.req_rdy}, 32'd1);

    // Known contents for the modelled window of both RAMs
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < NW; i++) txn(BASE + 32'(4 * i), 4'd0, 4'hF, $urandom, 0, rd);
    end

    sel = 0;
    txn(32'h8000_0010, 4'd0, 4'hF, 32'hDEAD_BEEF, 0, rd);
    txn(32'h8000_0010, 4'hF, 4'd0, 32'd0, 0, rd);
    check("word_readback", rd, 32'hDEAD_BEEF);

    txn(32'h8000_0020, 4'd0, 4'hF, 32'h1122_3344, 1, rd);
    txn(32'h8000_0020, 4'd0, 4'b0100, 32'h00AA_0000, 0, rd);
    txn(32'h8000_0020, 4'hF, 4'd0, 32'd0, 2, rd);
    check("lane_merge", rd, 32'h11AA_3344);
    txn(32'h8000_0020, 4'b1100, 4'd0, 32'd0, 0, rd);
    check("upper_half_read", rd, 32'h11AA_0000);

    txn(32'h7FFF_FFFC, 4'hF, 4'd0, 32'd0, 0, rd);
    txn(32'h8000_1000, 4'd0, 4'hF, 32'hFFFF_FFFF, 0, rd);
    txn(32'h8000_0010, 4'd0, 4'b0101, 32'h0000_0000, 0, rd);
    txn(32'h8000_0020, 4'hF, 4'hF, 32'h0000_0000, 0, rd);
    txn(32'h8000_0010, 4'hF, 4'd0, 32'd0, 0, rd);
    check("err_no_write_10", rd, 32'hDEAD_BEEF);
    txn(32'h8000_0020, 4'hF, 4'd0, 32'd0, 0, rd);
    check("err_no_write_20", rd, 32'h11AA_3344);

    // Back-pressure on both wait-state configurations
    txn(32'h8000_0010, 4'hF, 4'd0, 32'd0, 5, rd);
    sel = 1;
    txn(32'h8000_0030, 4'd0, 4'hF, 32'hCAFE_F00D, 5, rd);
    txn(32'h8000_0030, 4'hF, 4'd0, 32'd0, 5, rd);
    check("wait0_readback", rd, 32'hCAFE_F00D);

    // Reset while the write sits in WAIT
    sel = 0;
    @(negedge clk);
    req_addr = 32'h8000_0040; req_rden = 4'd0; req_wren = 4'hF; req_wrdata = 32'h5555_5555;
    req_vld = 1'b1;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_vld = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_vld |= bus2.rsp_vld;
    end
    check("rst_in_wait_no_rsp", {31'd0, saw_vld}, 32'd0);
    check("rst_in_wait_req_rdy", {31'd0, bus2.req_rdy}, 32'd1);
    txn(32'h8000_0040, 4'hF, 4'd0, 32'd0, 0, rd);
    check("rst_in_wait_old", rd, mdl[0][16]);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 150; i++) rand_txn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
